// File: rtl/led_event_monitor_pkg.sv
// Shared definitions for the LED event monitor: default parameters, FSM
// state encoding and a counter-width helper.
package led_event_monitor_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PERIOD     = 50000;
    localparam int DEF_HEARTBEATS = 4;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_TS_W       = 32;

    typedef enum logic [1:0] {
        ST_BASELINE = 2'd0,
        ST_RUN      = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on rd_data_o while
// not empty; a read simply advances past it.
module sync_fifo #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_wr;
    logic              do_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    assign rd_data_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = do_wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_rd ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is left unreset; the count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/led_event_monitor.sv
// Watches a bus for value changes, queues timestamped events in a FIFO and
// emits periodic heartbeats until a fixed number of them have elapsed.
module led_event_monitor
    import led_event_monitor_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PERIOD     = DEF_PERIOD,
    parameter int HEARTBEATS = DEF_HEARTBEATS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TS_W       = DEF_TS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic [TS_W-1:0]  evt_time,
    output logic             heartbeat,
    output logic             done,
    output logic             overflow
);

    localparam int PER_W = cnt_width(PERIOD - 1);
    localparam int HB_W  = cnt_width(HEARTBEATS);
    localparam int ENT_W = WIDTH + TS_W;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEATS - 1);

    state_e           state_q, state_d;
    logic [TS_W-1:0]  cyc_q, cyc_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [HB_W-1:0]  beats_q, beats_d;
    logic             hb_q, hb_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic             period_end;
    logic             last_beat;
    logic             push;
    logic             pop;
    logic             fifo_wr;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_wdata;
    logic [ENT_W-1:0] fifo_rdata;

    assign period_end = (per_q == PER_LAST);
    assign last_beat  = period_end && (beats_q == HB_LAST);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        unique case (state_q)
            ST_BASELINE: begin
                push    = 1'b1;
                prev_d  = led_in;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (led_in != prev_q) begin
                    push   = 1'b1;
                    prev_d = led_in;
                end
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_BASELINE;
            end
        endcase
    end

    // A change that finds the FIFO full is lost unless the consumer pops in the same cycle.
    assign pop        = !fifo_empty && evt_ready;
    assign fifo_wr    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign fifo_wdata = {led_in, cyc_q};

    always_comb begin
        cyc_d   = cyc_q + TS_W'(1);
        per_d   = period_end ? '0 : per_q + PER_W'(1);
        hb_d    = (state_q == ST_RUN) && period_end;
        beats_d = hb_d ? beats_q + HB_W'(1) : beats_q;
        ovf_d   = ovf_q | drop;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BASELINE;
            cyc_q   <= '0;
            per_q   <= '0;
            beats_q <= '0;
            hb_q    <= 1'b0;
            ovf_q   <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            per_q   <= per_d;
            beats_q <= beats_d;
            hb_q    <= hb_d;
            ovf_q   <= ovf_d;
            prev_q  <= prev_d;
        end
    end

    sync_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Event fields read as zero whenever no event is queued.
    assign evt_valid = !fifo_empty;
    assign evt_data  = evt_valid ? fifo_rdata[ENT_W-1:TS_W] : '0;
    assign evt_time  = evt_valid ? fifo_rdata[TS_W-1:0]     : '0;
    assign heartbeat = hb_q;
    assign done      = (state_q == ST_DONE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_led_event_monitor.sv
// Self-checking bench for led_event_monitor: directed scenarios plus randomized
// traffic compared against a cycle-indexed reference model.
module tb_led_event_monitor;

    localparam int W  = 8;
    localparam int P  = 10;
    localparam int H  = 4;
    localparam int D  = 4;
    localparam int TW = 32;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] ts;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  led_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [W-1:0]  evt_data;
    logic [TW-1:0] evt_time;
    logic          heartbeat;
    logic          done;
    logic          overflow;

    // Reference model: k is the cycle index since reset release (equals the timestamp).
    int           k;
    ev_t          mq[$];
    logic [W-1:0] m_prev;
    bit           m_ovf;
    ev_t          got[$];

    int passed = 0;
    int total  = 0;

    led_event_monitor #(
        .WIDTH(W), .PERIOD(P), .HEARTBEATS(H), .DEPTH(D), .TS_W(TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_time  (evt_time),
        .heartbeat (heartbeat),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic bit exp_hb(input int kk);
        return (kk > 0) && (kk % P == 0) && (kk / P <= H);
    endfunction

    // Drive one cycle of stimulus, record accepted events, advance the model.
    task automatic step(input logic [W-1:0] led, input logic rdy);
        bit was_full;
        bit pop;
        bit push;
        led_in    = led;
        evt_ready = rdy;
        if (rdy && evt_valid === 1'b1) got.push_back({evt_data, evt_time});
        was_full = (mq.size() == D);
        pop      = rdy && (mq.size() > 0);
        push     = (k == 0) || ((k < P * H) && (led != m_prev));
        if (pop) void'(mq.pop_front());
        if (push) begin
            m_prev = led;
            if (!was_full || pop) mq.push_back({led, TW'(k)});
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic model_clear();
        k = 0;
        mq.delete();
        got.delete();
        m_ovf  = 1'b0;
        m_prev = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        led_in    = 8'hA5;
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", evt_valid); else passed++;
        total++; if (heartbeat !== 1'b0) $display("FAIL reset_hb got=%b exp=0", heartbeat); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else passed++;
        total++; if (evt_data !== 8'h00 || evt_time !== 32'd0)
            $display("FAIL reset_fields got=%h/%h exp=00/0", evt_data, evt_time); else passed++;
        rst = 1'b0;
        model_clear();
        step(8'hA5, 1'b0);
        total++; if (evt_valid !== 1'b1 || evt_data !== 8'hA5 || evt_time !== 32'd0)
            $display("FAIL baseline_evt got=%b %h/%0d exp=1 a5/0", evt_valid, evt_data, evt_time); else passed++;
    endtask

    task automatic test_heartbeat();
        int  pulses;
        ev_t e;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 55; c++) begin
            total++; if (heartbeat !== exp_hb(k))
                $display("FAIL hb_cycle k=%0d got=%b exp=%b", k, heartbeat, exp_hb(k)); else passed++;
            total++; if (done !== (k >= P * H))
                $display("FAIL done_cycle k=%0d got=%b exp=%b", k, done, (k >= P * H)); else passed++;
            if (heartbeat === 1'b1) pulses++;
            step(8'h00, 1'b1);
        end
        total++; if (pulses != H) $display("FAIL hb_count got=%0d exp=%0d", pulses, H); else passed++;
        e = {8'h00, 32'd0};
        total++; if (got.size() != 1) $display("FAIL const_evt_count got=%0d exp=1", got.size()); else passed++;
        if (got.size() > 0) begin
            total++; if (got[0] !== e) $display("FAIL const_evt got=%h exp=%h", got[0], e); else passed++;
        end
    endtask

    task automatic test_sequence();
        ev_t exp_ev[3];
        exp_ev[0] = {8'h00, 32'd0};
        exp_ev[1] = {8'h01, 32'd5};
        exp_ev[2] = {8'h03, 32'd7};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step((c < 5) ? 8'h00 : (c < 7) ? 8'h01 : 8'h03, 1'b1);
        end
        total++; if (got.size() != 3) $display("FAIL seq_count got=%0d exp=3", got.size()); else passed++;
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_ev[i]) $display("FAIL seq_evt%0d got=%h exp=%h", i, got[i], exp_ev[i]); else passed++;
        end
    endtask

    task automatic test_overflow();
        ev_t exp_ev[4];
        for (int i = 0; i < 4; i++) exp_ev[i] = {W'(i), TW'(i)};
        do_reset();
        step(8'h00, 1'b0);
        for (int i = 1; i <= 6; i++) step(W'(i), 1'b0);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow); else passed++;
        total++; if (evt_valid !== 1'b1 || evt_data !== 8'h00 || evt_time !== 32'd0)
            $display("FAIL ovf_head_hold got=%b %h/%0d exp=1 00/0", evt_valid, evt_data, evt_time); else passed++;
        for (int c = 0; c < 8; c++) step(8'h06, 1'b1);
        total++; if (got.size() != 4) $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); else passed++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_ev[i]) $display("FAIL ovf_evt%0d got=%h exp=%h", i, got[i], exp_ev[i]); else passed++;
        end
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else passed++;
        total++; if (evt_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", evt_valid); else passed++;
    endtask

    task automatic test_full_pop();
        ev_t exp_ev[4];
        for (int i = 0; i < 4; i++) exp_ev[i] = {W'(i + 1), TW'(i + 1)};
        do_reset();
        for (int i = 0; i < 4; i++) step(W'(i), 1'b0);
        step(8'h04, 1'b1);
        total++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got=%b exp=0", overflow); else passed++;
        total++; if (evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_time !== 32'd1)
            $display("FAIL fullpop_head got=%b %h/%0d exp=1 01/1", evt_valid, evt_data, evt_time); else passed++;
        got.delete();
        for (int c = 0; c < 6; c++) step(8'h04, 1'b1);
        total++; if (got.size() != 4) $display("FAIL fullpop_count got=%0d exp=4", got.size()); else passed++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_ev[i]) $display("FAIL fullpop_evt%0d got=%h exp=%h", i, got[i], exp_ev[i]); else passed++;
        end
        total++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf_end got=%b exp=0", overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 25; c++) step((c < 3) ? 8'h00 : (c < 8) ? 8'h01 : 8'h02, 1'b0);
        total++; if (evt_valid !== 1'b1) $display("FAIL mid_queued got=%b exp=1", evt_valid); else passed++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (evt_valid !== 1'b0) $display("FAIL mid_flush got=%b exp=0", evt_valid); else passed++;
        total++; if (evt_data !== 8'h00 || evt_time !== 32'd0)
            $display("FAIL mid_fields got=%h/%h exp=00/0", evt_data, evt_time); else passed++;
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 13; c++) begin
            if (k == 1) begin
                total++; if (evt_valid !== 1'b1 || evt_data !== 8'h05 || evt_time !== 32'd0)
                    $display("FAIL mid_baseline got=%b %h/%0d exp=1 05/0", evt_valid, evt_data, evt_time); else passed++;
            end
            total++; if (heartbeat !== exp_hb(k))
                $display("FAIL mid_hb k=%0d got=%b exp=%b", k, heartbeat, exp_hb(k)); else passed++;
            step(8'h05, 1'b0);
        end
    endtask

    task automatic test_done();
        ev_t exp_ev[3];
        exp_ev[0] = {8'h00, 32'd0};
        exp_ev[1] = {8'h01, 32'd38};
        exp_ev[2] = {8'h02, 32'd39};
        do_reset();
        for (int c = 0; c < 60; c++) begin
            step((c < 38) ? 8'h00 : (c == 38) ? 8'h01 : (c == 39) ? 8'h02 : (c % 2 == 1) ? 8'h03 : 8'h04, 1'b0);
        end
        total++; if (done !== 1'b1) $display("FAIL done_sticky got=%b exp=1", done); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL done_ovf got=%b exp=0", overflow); else passed++;
        for (int c = 0; c < 6; c++) step((c % 2 == 1) ? 8'h03 : 8'h04, 1'b1);
        total++; if (got.size() != 3) $display("FAIL done_drain_count got=%0d exp=3", got.size()); else passed++;
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_ev[i]) $display("FAIL done_evt%0d got=%h exp=%h", i, got[i], exp_ev[i]); else passed++;
        end
        total++; if (evt_valid !== 1'b0) $display("FAIL done_empty got=%b exp=0", evt_valid); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] cur;
        logic         rdy;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            cur = W'($urandom);
            for (int c = 0; c < 70; c++) begin
                total++; if (evt_valid !== (mq.size() > 0))
                    $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, evt_valid, (mq.size() > 0)); else passed++;
                if (mq.size() > 0) begin
                    total++; if ({evt_data, evt_time} !== mq[0])
                        $display("FAIL rnd_head k=%0d got=%h/%0d exp=%h", k, evt_data, evt_time, mq[0]); else passed++;
                end
                total++; if (heartbeat !== exp_hb(k))
                    $display("FAIL rnd_hb k=%0d got=%b exp=%b", k, heartbeat, exp_hb(k)); else passed++;
                total++; if (done !== (k >= P * H))
                    $display("FAIL rnd_done k=%0d got=%b exp=%b", k, done, (k >= P * H)); else passed++;
                total++; if (overflow !== m_ovf)
                    $display("FAIL rnd_ovf k=%0d got=%b exp=%b", k, overflow, m_ovf); else passed++;
                if ($urandom_range(0, 9) < 3) cur = W'($urandom);
                rdy = ($urandom_range(0, 9) < 4);
                step(cur, rdy);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        led_in    = '0;
        evt_ready = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_heartbeat();
        test_sequence();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_done();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
